codec_i2s_intf: RTL



---
 rtl/codec_i2s_intf.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/codec_i2s_intf.sv
// I2S codec-side interface: generates BCLK/LRCLK, deserialises ADC words into
// a stereo sample with a VALID strobe, and serialises the core's output to the DAC.
module codec_i2s_intf #(
    parameter int SCLK_DIV  = 4,
    parameter int WORD_W    = 16,
    parameter int SLOT_BITS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ADCDAT,
    output logic              BCLK,
    output logic              LRCLK,
    output logic              DACDAT,
    output logic              VALID,
    output logic [WORD_W-1:0] left_rx,
    output logic [WORD_W-1:0] right_rx,
    input  logic [WORD_W-1:0] left_tx,
    input  logic [WORD_W-1:0] right_tx
);
    localparam int FRAME = 2 * SLOT_BITS;
    localparam int CW    = $clog2(FRAME);
    localparam int DW    = $clog2(SCLK_DIV);

    logic [DW-1:0]     div_q, div_d;
    logic [CW-1:0]     bit_q, bit_d;
    logic              bclk_q, bclk_d;
    logic              lrclk_q, lrclk_d;
    logic              dac_q, dac_d;
    logic              valid_q, valid_d;
    logic              vpend_q, vpend_d;
    logic              sync1_q, sync2_q;
    logic [WORD_W-1:0] rxsh_q, rxsh_d;
    logic [WORD_W-1:0] lhold_q, lhold_d;
    logic [WORD_W-1:0] lrx_q, lrx_d;
    logic [WORD_W-1:0] rrx_q, rrx_d;
    logic [WORD_W-1:0] txl_q, txl_d;
    logic [WORD_W-1:0] txr_q, txr_d;

    logic              tick, rise, fall;
    logic              slot, slot_n, in_word, in_word_n;
    logic [CW-1:0]     bit_nx, idx, idx_n;
    logic [WORD_W-1:0] tx_word, tx_shift;

    always_comb begin
        tick   = (div_q == DW'(SCLK_DIV - 1));
        rise   = tick & ~bclk_q;
        fall   = tick & bclk_q;
        div_d  = tick ? '0 : div_q + 1'b1;
        bclk_d = bclk_q ^ tick;

        bit_nx    = (bit_q == CW'(FRAME - 1)) ? '0 : bit_q + 1'b1;
        slot      = (bit_q >= CW'(SLOT_BITS));
        idx       = slot ? bit_q - CW'(SLOT_BITS) : bit_q;
        in_word   = (idx != '0) && (idx <= CW'(WORD_W));
        slot_n    = (bit_nx >= CW'(SLOT_BITS));
        idx_n     = slot_n ? bit_nx - CW'(SLOT_BITS) : bit_nx;
        in_word_n = (idx_n != '0) && (idx_n <= CW'(WORD_W));

        // MSB-first: bit WORD_W-idx is the top bit after shifting left by idx-1
        tx_word  = slot_n ? txr_q : txl_q;
        tx_shift = tx_word << (idx_n - 1'b1);

        bit_d   = bit_q;
        lrclk_d = lrclk_q;
        dac_d   = dac_q;
        txl_d   = txl_q;
        txr_d   = txr_q;
        rxsh_d  = rxsh_q;
        lhold_d = lhold_q;
        lrx_d   = lrx_q;
        rrx_d   = rrx_q;
        vpend_d = vpend_q;
        valid_d = 1'b0;

        if (vpend_q) begin
            valid_d = 1'b1;
            vpend_d = 1'b0;
            lrx_d   = lhold_q;
            rrx_d   = rxsh_q;
        end

        if (fall) begin
            bit_d   = bit_nx;
            lrclk_d = slot_n;
            dac_d   = in_word_n & tx_shift[WORD_W-1];
            if (bit_nx == '0) begin
                txl_d = left_tx;
                txr_d = right_tx;
            end
        end

        if (rise && in_word) begin
            rxsh_d = {rxsh_q[WORD_W-2:0], sync2_q};
            if (idx == CW'(WORD_W)) begin
                if (!slot) lhold_d = rxsh_d;
                else       vpend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q   <= '0;
            bit_q   <= '0;
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            dac_q   <= 1'b0;
            valid_q <= 1'b0;
            vpend_q <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            rxsh_q  <= '0;
            lhold_q <= '0;
            lrx_q   <= '0;
            rrx_q   <= '0;
            txl_q   <= '0;
            txr_q   <= '0;
        end else begin
            div_q   <= div_d;
            bit_q   <= bit_d;
            bclk_q  <= bclk_d;
            lrclk_q <= lrclk_d;
            dac_q   <= dac_d;
            valid_q <= valid_d;
            vpend_q <= vpend_d;
            sync1_q <= ADCDAT;
            sync2_q <= sync1_q;
            rxsh_q  <= rxsh_d;
            lhold_q <= lhold_d;
            lrx_q   <= lrx_d;
            rrx_q   <= rrx_d;
            txl_q   <= txl_d;
            txr_q   <= txr_d;
        end
    end

    assign BCLK     = bclk_q;
    assign LRCLK    = lrclk_q;
    assign DACDAT   = dac_q;
    assign VALID    = valid_q;
    assign left_rx  = lrx_q;
    assign right_rx = rrx_q;

endmodule
